// File: rtl/mod_updown_counter.sv
// ----------------------------------------------------------------------------
// mod_updown_counter
//   Parametrised synchronous up/down modulo counter. A WIDTH-bit count
//   register with enable, direction, synchronous clear/load and a selectable
//   limit behaviour: wrap (MODE=0), saturate (MODE=1) or one-shot (MODE=2).
//   The combinational terminal-count output lets counters cascade by tying
//   the next stage's en to this stage's tc.
//
// Parameters
//   WIDTH    count register width, 1..32
//   MODULUS  count range 0..MODULUS-1, legal 2..2**WIDTH
//   MODE     0 = wrap, 1 = saturate, 2 = one-shot
//
// Ports
//   clk      in   1      rising-edge clock
//   reset_n  in   1      asynchronous active-low reset
//   en       in   1      count enable (cascade input)
//   up_dn    in   1      1 = count up, 0 = count down
//   clr      in   1      synchronous clear to 0 (highest priority)
//   load     in   1      synchronous load of d (clamped to MODULUS-1)
//   d        in   WIDTH  load value
//   q        out  WIDTH  current count (registered)
//   qb       out  WIDTH  bitwise complement of q
//   tc       out  1      en && q at the limit for the current direction
//   done     out  1      one-shot finished flag (registered, 0 unless MODE=2)
// ----------------------------------------------------------------------------
module mod_updown_counter #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd10,
  parameter int              MODE    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             done
);

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("mod_updown_counter: MODE must be 0, 1 or 2");
  end

  localparam logic [WIDTH-1:0] LIMIT_HI = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] LIMIT_LO = {WIDTH{1'b0}};

  // One-shot sequencing. Outside MODE=2 the state never leaves ST_RUN.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Load value clamped into the legal count range.
  function automatic logic [WIDTH-1:0] f_clamp_load(input logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] res;
    if (64'(val) < MODULUS) begin
      res = val;
    end else begin
      res = LIMIT_HI;
    end
    return res;
  endfunction

  // Plain WIDTH-bit increment/decrement; limit handling is done by the caller.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] val,
                                              input logic             dir_up);
    logic [WIDTH-1:0] res;
    if (dir_up) begin
      res = val + WIDTH'(1'b1);
    end else begin
      res = val - WIDTH'(1'b1);
    end
    return res;
  endfunction

  logic [WIDTH-1:0] r_q;
  logic             r_done;
  state_t           r_state;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_done_nxt;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_limit;
  logic             w_at_limit;

  // Limit for the current direction and terminal-count detect.
  always_comb begin
    w_limit    = LIMIT_LO;
    w_at_limit = 1'b0;
    if (up_dn) begin
      w_limit = LIMIT_HI;
    end else begin
      w_limit = LIMIT_LO;
    end
    w_at_limit = (r_q == w_limit);
  end

  // Next-state logic: clr > load > en; one-shot freezes once finished.
  always_comb begin
    w_q_nxt     = r_q;
    w_done_nxt  = r_done;
    w_state_nxt = r_state;
    if (clr) begin
      w_q_nxt     = {WIDTH{1'b0}};
      w_done_nxt  = 1'b0;
      w_state_nxt = ST_RUN;
    end else if (load) begin
      w_q_nxt     = f_clamp_load(d);
      w_done_nxt  = 1'b0;
      w_state_nxt = ST_RUN;
    end else if (en) begin
      case (r_state)
        ST_RUN: begin
          if (!w_at_limit) begin
            w_q_nxt = f_step(r_q, up_dn);
          end else begin
            case (MODE)
              0: begin
                // Wrap to the opposite end of the range.
                if (up_dn) begin
                  w_q_nxt = LIMIT_LO;
                end else begin
                  w_q_nxt = LIMIT_HI;
                end
              end
              1: begin
                w_q_nxt = r_q;
              end
              2: begin
                w_q_nxt     = r_q;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_DONE;
              end
              default: begin
                w_q_nxt = r_q;
              end
            endcase
          end
        end
        ST_DONE: begin
          // Frozen until clr or load, regardless of en/up_dn.
          w_q_nxt     = r_q;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_q_nxt     = r_q;
          w_done_nxt  = 1'b0;
          w_state_nxt = ST_RUN;
        end
      endcase
    end else begin
      w_q_nxt     = r_q;
      w_done_nxt  = r_done;
      w_state_nxt = r_state;
    end
  end

  // Count, done flag and one-shot state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q     <= {WIDTH{1'b0}};
      r_done  <= 1'b0;
      r_state <= ST_RUN;
    end else begin
      r_q     <= w_q_nxt;
      r_done  <= w_done_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign q    = r_q;
  assign qb   = ~r_q;
  assign tc   = en & w_at_limit;
  assign done = r_done;

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // stage0: W4 M10 wrap
  logic s0_en, s0_up, s0_clr, s0_load;
  logic [3:0] s0_d, s0_q, s0_qb;
  logic s0_tc, s0_done;
  // stage1: W4 M10 wrap, cascaded on stage0 tc
  logic s1_up, s1_clr, s1_load;
  logic [3:0] s1_d, s1_q, s1_qb;
  logic s1_tc, s1_done;
  // saturate: W4 M10
  logic st_en, st_up, st_clr, st_load;
  logic [3:0] st_d, st_q, st_qb;
  logic st_tc, st_done;
  // one-shot: W4 M10
  logic os_en, os_up, os_clr, os_load;
  logic [3:0] os_d, os_q, os_qb;
  logic os_tc, os_done;
  // one-shot: W4 M7
  logic o7_en, o7_up, o7_clr, o7_load;
  logic [3:0] o7_d, o7_q, o7_qb;
  logic o7_tc, o7_done;

  mod_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .MODE(0)) u_s0 (
    .clk(clk), .reset_n(reset_n), .en(s0_en), .up_dn(s0_up), .clr(s0_clr),
    .load(s0_load), .d(s0_d), .q(s0_q), .qb(s0_qb), .tc(s0_tc), .done(s0_done));

  mod_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .MODE(0)) u_s1 (
    .clk(clk), .reset_n(reset_n), .en(s0_tc), .up_dn(s1_up), .clr(s1_clr),
    .load(s1_load), .d(s1_d), .q(s1_q), .qb(s1_qb), .tc(s1_tc), .done(s1_done));

  mod_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .MODE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .en(st_en), .up_dn(st_up), .clr(st_clr),
    .load(st_load), .d(st_d), .q(st_q), .qb(st_qb), .tc(st_tc), .done(st_done));

  mod_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .MODE(2)) u_os (
    .clk(clk), .reset_n(reset_n), .en(os_en), .up_dn(os_up), .clr(os_clr),
    .load(os_load), .d(os_d), .q(os_q), .qb(os_qb), .tc(os_tc), .done(os_done));

  mod_updown_counter #(.WIDTH(4), .MODULUS(64'd7), .MODE(2)) u_o7 (
    .clk(clk), .reset_n(reset_n), .en(o7_en), .up_dn(o7_up), .clr(o7_clr),
    .load(o7_load), .d(o7_d), .q(o7_q), .qb(o7_qb), .tc(o7_tc), .done(o7_done));

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if (s0_q !== 4'd0) begin
      failures++; $display("FAIL reset_q: got %0d expected 0", s0_q);
    end
    checks++;
    if (s0_qb !== 4'hF) begin
      failures++; $display("FAIL reset_qb: got %h expected f", s0_qb);
    end
    checks++;
    if (s0_tc !== 1'b0) begin
      failures++; $display("FAIL reset_tc: got %b expected 0", s0_tc);
    end
    checks++;
    if (os_done !== 1'b0 || os_q !== 4'd0) begin
      failures++; $display("FAIL reset_os: got q=%0d done=%b expected q=0 done=0", os_q, os_done);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_q;
    exp_q = 4'd0;
    @(negedge clk);
    s0_en = 1'b1; s0_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++;
      if (s0_tc !== (exp_q == 4'd9)) begin
        failures++; $display("FAIL wrap_up_tc: q=%0d got tc=%b expected %b", exp_q, s0_tc, (exp_q == 4'd9));
      end
      @(posedge clk); #1;
      exp_q = (exp_q == 4'd9) ? 4'd0 : exp_q + 4'd1;
      checks++;
      if (s0_q !== exp_q || s0_qb !== ~exp_q) begin
        failures++; $display("FAIL wrap_up_q: step %0d got q=%0d qb=%h expected q=%0d", i, s0_q, s0_qb, exp_q);
      end
    end
    checks++;
    if (s0_q !== 4'd2 || s0_done !== 1'b0) begin
      failures++; $display("FAIL wrap_up_end: got q=%0d done=%b expected q=2 done=0", s0_q, s0_done);
    end
    @(negedge clk);
    s0_en = 1'b0;
  endtask

  task automatic test_down_and_saturate();
    logic [3:0] exp_q;
    @(negedge clk);
    s0_clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s0_q !== 4'd0) begin
      failures++; $display("FAIL down_clr: got %0d expected 0", s0_q);
    end
    @(negedge clk);
    s0_clr = 1'b0; s0_en = 1'b1; s0_up = 1'b0;
    #1;
    checks++;
    if (s0_tc !== 1'b1) begin
      failures++; $display("FAIL down_tc_at0: got %b expected 1", s0_tc);
    end
    exp_q = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp_q = (exp_q == 4'd0) ? 4'd9 : exp_q - 4'd1;
      checks++;
      if (s0_q !== exp_q || s0_tc !== 1'b0) begin
        failures++; $display("FAIL down_q: got q=%0d tc=%b expected q=%0d tc=0", s0_q, s0_tc, exp_q);
      end
    end
    @(negedge clk);
    s0_en = 1'b0;
    st_load = 1'b1; st_d = 4'd1;
    @(posedge clk); #1;
    checks++;
    if (st_q !== 4'd1) begin
      failures++; $display("FAIL sat_load: got %0d expected 1", st_q);
    end
    @(negedge clk);
    st_load = 1'b0; st_en = 1'b1; st_up = 1'b0;
    #1;
    checks++;
    if (st_tc !== 1'b0) begin
      failures++; $display("FAIL sat_tc_at1: got %b expected 0", st_tc);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (st_q !== 4'd0 || st_tc !== 1'b1 || st_done !== 1'b0) begin
        failures++; $display("FAIL sat_hold: got q=%0d tc=%b done=%b expected q=0 tc=1 done=0", st_q, st_tc, st_done);
      end
    end
    @(negedge clk);
    st_en = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [3:0] exp_q;
    logic       exp_done;
    @(negedge clk);
    os_load = 1'b1; os_d = 4'd7; os_up = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (os_q !== 4'd7 || os_done !== 1'b0) begin
      failures++; $display("FAIL os_load7: got q=%0d done=%b expected q=7 done=0", os_q, os_done);
    end
    @(negedge clk);
    os_load = 1'b0; os_en = 1'b1;
    exp_q = 4'd7; exp_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (exp_q == 4'd9) exp_done = 1'b1;
      else exp_q = exp_q + 4'd1;
      checks++;
      if (os_q !== exp_q || os_done !== exp_done) begin
        failures++; $display("FAIL os_run: step %0d got q=%0d done=%b expected q=%0d done=%b", i, os_q, os_done, exp_q, exp_done);
      end
    end
    @(negedge clk);
    os_up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (os_q !== 4'd9 || os_done !== 1'b1 || os_tc !== 1'b0) begin
        failures++; $display("FAIL os_frozen: got q=%0d done=%b tc=%b expected q=9 done=1 tc=0", os_q, os_done, os_tc);
      end
    end
    @(negedge clk);
    os_load = 1'b1; os_d = 4'd3;
    @(posedge clk); #1;
    checks++;
    if (os_q !== 4'd3 || os_done !== 1'b0) begin
      failures++; $display("FAIL os_reload: got q=%0d done=%b expected q=3 done=0", os_q, os_done);
    end
    @(negedge clk);
    os_load = 1'b0; os_en = 1'b0;
  endtask

  task automatic test_priority();
    @(negedge clk);
    s0_load = 1'b1; s0_d = 4'd4;
    @(posedge clk); #1;
    checks++;
    if (s0_q !== 4'd4) begin
      failures++; $display("FAIL prio_load4: got %0d expected 4", s0_q);
    end
    @(negedge clk);
    s0_clr = 1'b1; s0_load = 1'b1; s0_d = 4'd5; s0_en = 1'b1; s0_up = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s0_q !== 4'd0) begin
      failures++; $display("FAIL prio_clr_wins: got %0d expected 0", s0_q);
    end
    @(negedge clk);
    s0_clr = 1'b0; s0_load = 1'b1; s0_d = 4'd14; s0_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s0_q !== 4'd9) begin
      failures++; $display("FAIL prio_clamp: got %0d expected 9", s0_q);
    end
    @(negedge clk);
    s0_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (s0_q !== 4'd9 || s0_tc !== 1'b0) begin
        failures++; $display("FAIL prio_hold: got q=%0d tc=%b expected q=9 tc=0", s0_q, s0_tc);
      end
    end
    @(negedge clk);
    s0_en = 1'b1;
    #1;
    checks++;
    if (s0_tc !== 1'b1) begin
      failures++; $display("FAIL prio_tc_comb: got %b expected 1", s0_tc);
    end
    #1;
    s0_en = 1'b0;
  endtask

  task automatic test_cascade();
    logic [3:0] exp0, exp1;
    @(negedge clk);
    s0_clr = 1'b1; s1_clr = 1'b1; s0_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s0_q !== 4'd0 || s1_q !== 4'd0) begin
      failures++; $display("FAIL casc_clr: got %0d%0d expected 00", s1_q, s0_q);
    end
    @(negedge clk);
    s0_clr = 1'b0; s1_clr = 1'b0; s0_en = 1'b1; s0_up = 1'b1; s1_up = 1'b1;
    exp0 = 4'd0; exp1 = 4'd0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (exp0 == 4'd9) exp1 = (exp1 == 4'd9) ? 4'd0 : exp1 + 4'd1;
      exp0 = (exp0 == 4'd9) ? 4'd0 : exp0 + 4'd1;
      checks++;
      if (s0_q !== exp0 || s1_q !== exp1) begin
        failures++; $display("FAIL casc_step: cycle %0d got %0d%0d expected %0d%0d", i, s1_q, s0_q, exp1, exp0);
      end
    end
    checks++;
    if ({s1_q, s0_q} !== 8'h00) begin
      failures++; $display("FAIL casc_final: got %h expected 00", {s1_q, s0_q});
    end
    @(negedge clk);
    s0_en = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    o7_load = 1'b1; o7_d = 4'd5; o7_up = 1'b1;
    s0_load = 1'b1; s0_d = 4'd3;
    @(posedge clk); #1;
    checks++;
    if (o7_q !== 4'd5 || s0_q !== 4'd3) begin
      failures++; $display("FAIL ar_load: got o7=%0d s0=%0d expected 5 3", o7_q, s0_q);
    end
    @(negedge clk);
    o7_load = 1'b0; o7_en = 1'b1; s0_load = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (o7_q !== 4'd6 || o7_done !== 1'b1) begin
      failures++; $display("FAIL ar_pre: got q=%0d done=%b expected q=6 done=1", o7_q, o7_done);
    end
    @(negedge clk);
    o7_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (o7_q !== 4'd0 || o7_done !== 1'b0 || s0_q !== 4'd0) begin
      failures++; $display("FAIL ar_async: got q=%0d done=%b s0=%0d expected q=0 done=0 s0=0", o7_q, o7_done, s0_q);
    end
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    o7_en = 1'b1; s0_en = 1'b1; s0_up = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o7_q !== 4'd1 || o7_done !== 1'b0 || s0_q !== 4'd1) begin
      failures++; $display("FAIL ar_resume: got q=%0d done=%b s0=%0d expected q=1 done=0 s0=1", o7_q, o7_done, s0_q);
    end
    @(negedge clk);
    o7_en = 1'b0; s0_en = 1'b0;
  endtask

  initial begin
    s0_en = 1'b0; s0_up = 1'b1; s0_clr = 1'b0; s0_load = 1'b0; s0_d = 4'd0;
    s1_up = 1'b1; s1_clr = 1'b0; s1_load = 1'b0; s1_d = 4'd0;
    st_en = 1'b0; st_up = 1'b1; st_clr = 1'b0; st_load = 1'b0; st_d = 4'd0;
    os_en = 1'b0; os_up = 1'b1; os_clr = 1'b0; os_load = 1'b0; os_d = 4'd0;
    o7_en = 1'b0; o7_up = 1'b1; o7_clr = 1'b0; o7_load = 1'b0; o7_d = 4'd0;
    test_reset();
    test_wrap_up();
    test_down_and_saturate();
    test_oneshot();
    test_priority();
    test_cascade();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
